// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wisc_pkg
// Brief    : Shared constants and types for the 16-bit WISC pipeline.
// Revision : 1.0  initial release
// ============================================================================
package wisc_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus_two;
        logic        err;
    } fd_entry_t;

endpackage
`default_nettype wire

// File: rtl/fd_slot.sv
`default_nettype none
// ============================================================================
// Module   : fd_slot
// Brief    : One fetch/decode entry register with load enable and async clear.
// Revision : 1.0  initial release
// ============================================================================
module fd_slot
    import wisc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  fd_entry_t d,
    output fd_entry_t q
);

    fd_entry_t r_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
        end else if (load) begin
            r_entry <= d;
        end
    end

    assign q = r_entry;

endmodule
`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_buffer
// Brief    : Two-entry elastic buffer between fetch and decode with HALT stop.
// Revision : 1.0  initial release
// ============================================================================
module fetch_decode_buffer
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_plus_two,
    input  logic        if_err,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus_two,
    output logic        id_err,
    output logic        halt_seen,
    output logic [1:0]  occupancy
);

    // State encoding equals the number of held entries.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_halt_seen;
    logic       w_halt_next;
    logic       w_push;
    logic       w_pop;
    logic       w_head_load;
    logic       w_tail_load;
    fd_entry_t  w_in_entry;
    fd_entry_t  w_head_d;
    fd_entry_t  w_head_q;
    fd_entry_t  w_tail_q;

    assign w_in_entry = '{instr: if_instr, pc_plus_two: if_pc_plus_two, err: if_err};
    assign w_push     = if_valid & if_ready;
    assign w_pop      = id_valid & id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_empty;
            r_halt_seen <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_halt_seen <= w_halt_next;
        end
    end

    // Flush wins over everything, including a same-cycle HALT push.
    always_comb begin
        w_state_next = r_state;
        w_halt_next  = r_halt_seen;
        w_head_load  = 1'b0;
        w_tail_load  = 1'b0;
        w_head_d     = w_in_entry;
        if (flush) begin
            w_state_next = c_st_empty;
            w_halt_next  = 1'b0;
        end else begin
            if (w_push && (if_instr[15:11] == OP_HALT)) begin
                w_halt_next = 1'b1;
            end
            case (r_state)
                c_st_empty: begin
                    if (w_push) begin
                        w_head_load  = 1'b1;
                        w_state_next = c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_push && w_pop) begin
                        w_head_load = 1'b1;
                    end else if (w_push) begin
                        w_tail_load  = 1'b1;
                        w_state_next = c_st_two;
                    end else if (w_pop) begin
                        w_state_next = c_st_empty;
                    end
                end
                c_st_two: begin
                    if (w_pop) begin
                        w_head_d     = w_tail_q;
                        w_head_load  = 1'b1;
                        w_state_next = c_st_one;
                    end
                end
                default: begin
                    w_state_next = c_st_empty;
                end
            endcase
        end
    end

    always_comb begin
        if_ready       = (r_state != c_st_two) & ~r_halt_seen;
        id_valid       = (r_state != c_st_empty);
        id_instr       = id_valid ? w_head_q.instr       : NOP_INSTR;
        id_pc_plus_two = id_valid ? w_head_q.pc_plus_two : 16'h0000;
        id_err         = id_valid ? w_head_q.err         : 1'b0;
        halt_seen      = r_halt_seen;
        occupancy      = r_state;
    end

    fd_slot u_head (
        .clk  (clk),
        .rst  (rst),
        .load (w_head_load),
        .d    (w_head_d),
        .q    (w_head_q)
    );

    fd_slot u_tail (
        .clk  (clk),
        .rst  (rst),
        .load (w_tail_load),
        .d    (w_in_entry),
        .q    (w_tail_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_buffer
// Brief    : Directed self-checking bench for fetch_decode_buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_decode_buffer;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus_two;
    logic        if_err;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus_two;
    logic        id_err;
    logic        halt_seen;
    logic [1:0]  occupancy;

    int checks;
    int failures;

    fetch_decode_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc_plus_two (if_pc_plus_two),
        .if_err         (if_err),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc_plus_two (id_pc_plus_two),
        .id_err         (id_err),
        .halt_seen      (halt_seen),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc, input logic e);
        if_valid       = v;
        if_instr       = ins;
        if_pc_plus_two = pc;
        if_err         = e;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        flush    = 1'b0;
        id_ready = 1'b0;
        #12;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL reset_id_instr got=%h exp=0800", id_instr); end
        checks++; if (id_pc_plus_two !== 16'h0000) begin failures++; $display("FAIL reset_id_pc got=%h exp=0000", id_pc_plus_two); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (halt_seen !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt_seen); end
        rst = 1'b1;
        step();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    endtask

    task automatic test_single;
        drive(1'b1, 16'h4005, 16'h0002, 1'b1);
        id_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", id_valid); end
        checks++; if (id_instr !== 16'h4005) begin failures++; $display("FAIL single_instr got=%h exp=4005", id_instr); end
        checks++; if (id_pc_plus_two !== 16'h0002) begin failures++; $display("FAIL single_pc got=%h exp=0002", id_pc_plus_two); end
        checks++; if (id_err !== 1'b1) begin failures++; $display("FAIL single_err got=%b exp=1", id_err); end
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL single_drain_occ got=%0d exp=0", occupancy); end
        checks++; if (id_err !== 1'b0) begin failures++; $display("FAIL single_drain_err got=%b exp=0", id_err); end
    endtask

    task automatic test_backpressure;
        id_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h0100, 1'b0);
        step();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_one got=%b exp=1", if_ready); end
        drive(1'b1, 16'h2222, 16'h0102, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ_full got=%0d exp=2", occupancy); end
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", if_ready); end
        checks++; if (id_instr !== 16'h1111) begin failures++; $display("FAIL bp_head_first got=%h exp=1111", id_instr); end
        id_ready = 1'b1;
        step();
        checks++; if (id_instr !== 16'h2222) begin failures++; $display("FAIL bp_head_second got=%h exp=2222", id_instr); end
        checks++; if (id_pc_plus_two !== 16'h0102) begin failures++; $display("FAIL bp_pc_second got=%h exp=0102", id_pc_plus_two); end
        checks++; if (id_err !== 1'b1) begin failures++; $display("FAIL bp_err_second got=%b exp=1", id_err); end
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bp_occ_one got=%0d exp=1", occupancy); end
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL bp_empty_instr got=%h exp=0800", id_instr); end
    endtask

    task automatic test_stream;
        logic [15:0] exp_ins;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_ins = 16'h5000 + 16'(i);
            drive(1'b1, exp_ins, 16'h0200 + 16'(2 * i), 1'b0);
            step();
            checks++; if (id_instr !== exp_ins) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, id_instr, exp_ins); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_halt;
        id_ready = 1'b0;
        drive(1'b1, 16'h0000, 16'h0300, 1'b0);
        step();
        drive(1'b1, 16'h6666, 16'h0302, 1'b0);
        checks++; if (halt_seen !== 1'b1) begin failures++; $display("FAIL halt_seen got=%b exp=1", halt_seen); end
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL halt_if_ready got=%b exp=0", if_ready); end
        checks++; if (id_instr !== 16'h0000 || id_valid !== 1'b1) begin failures++; $display("FAIL halt_head got=%h/%b exp=0000/1", id_instr, id_valid); end
        step();
        step();
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL halt_blocks_push got=%0d exp=1", occupancy); end
        id_ready = 1'b1;
        step();
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halt_drained got=%b exp=0", id_valid); end
        checks++; if (halt_seen !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halt_seen); end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (halt_seen !== 1'b0) begin failures++; $display("FAIL halt_flush_clear got=%b exp=0", halt_seen); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL halt_flush_ready got=%b exp=1", if_ready); end
    endtask

    task automatic test_flush;
        id_ready = 1'b0;
        drive(1'b1, 16'h7777, 16'h0400, 1'b0);
        step();
        drive(1'b1, 16'h8888, 16'h0402, 1'b0);
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        drive(1'b1, 16'h3333, 16'h0404, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_full_occ got=%0d exp=0", occupancy); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_full_ready got=%b exp=1", if_ready); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL flush_full_instr got=%h exp=0800", id_instr); end
        // Push accepted by if_ready but discarded by flush, HALT included.
        drive(1'b1, 16'h0000, 16'h0500, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++; if (halt_seen !== 1'b0) begin failures++; $display("FAIL flush_halt_push got=%b exp=0", halt_seen); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_push_occ got=%0d exp=0", occupancy); end
        drive(1'b1, 16'h3333, 16'h0600, 1'b0);
        flush = 1'b1;
        id_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        checks++; if (id_valid !== 1'b0 || id_instr === 16'h3333) begin failures++; $display("FAIL flush_no_3333 got=%h/%b exp=0800/0", id_instr, id_valid); end
    endtask

    task automatic test_async_reset;
        id_ready = 1'b0;
        drive(1'b1, 16'h9001, 16'h0700, 1'b1);
        step();
        drive(1'b1, 16'h0000, 16'h0702, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++; if (occupancy !== 2'd2 || halt_seen !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=2/1", occupancy, halt_seen); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL ar_immediate_state got=%b/%0d exp=0/0", id_valid, occupancy); end
        checks++; if (id_instr !== 16'h0800 || id_pc_plus_two !== 16'h0000 || id_err !== 1'b0) begin failures++; $display("FAIL ar_immediate_out got=%h/%h/%b exp=0800/0000/0", id_instr, id_pc_plus_two, id_err); end
        checks++; if (halt_seen !== 1'b0) begin failures++; $display("FAIL ar_halt got=%b exp=0", halt_seen); end
        #3;
        rst = 1'b1;
        step();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL ar_release_ready got=%b exp=1", if_ready); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL ar_release_occ got=%0d exp=0", occupancy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_halt();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
